// File: rtl/cpu_jtag_debug_sysclk_bridge.sv
// System-clock half of the CPU JTAG debug path: resynchronises update strobes,
// captures the JTAG shift register and hands each command to the debug core over valid/ready.
module cpu_jtag_debug_sysclk_bridge #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = 34
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [SR_W-1:0]      sr,
    input  logic [IR_W-1:0]      ir_in,
    input  logic                 vs_udr,
    input  logic                 vs_uir,
    input  logic                 act_ready,
    input  logic                 overrun_clr,
    output logic [SR_W-1:0]      jdo,
    output logic                 act_valid,
    output logic [IR_W-1:0]      act_cmd,
    output logic                 act_take,
    output logic [2**IR_W-1:0]   take_action,
    output logic [2**IR_W-1:0]   take_no_action,
    output logic                 ir_update,
    output logic                 overrun
);

    localparam int NCMD = 2**IR_W;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_udr_sync;
    logic [SYNC_STAGES-1:0] r_uir_sync;
    logic                   r_udr_prev;
    logic                   r_uir_prev;
    logic [SR_W-1:0]        r_jdo;
    logic [IR_W-1:0]        r_act_cmd;
    logic                   r_act_take;
    logic [NCMD-1:0]        r_take_action;
    logic [NCMD-1:0]        r_take_no_action;
    logic                   r_ir_update;
    logic                   r_overrun;

    logic                   w_udr_synced;
    logic                   w_uir_synced;
    logic                   w_evt_udr;
    logic                   w_evt_uir;
    logic                   w_pending;
    logic                   w_accept;
    logic                   w_capture;
    logic                   w_drop;
    logic [NCMD-1:0]        w_cmd_onehot;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_udr_sync <= '0;
            r_uir_sync <= '0;
            r_udr_prev <= 1'b0;
            r_uir_prev <= 1'b0;
        end else begin
            r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
            r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
            r_udr_prev <= w_udr_synced;
            r_uir_prev <= w_uir_synced;
        end
    end

    assign w_udr_synced = r_udr_sync[SYNC_STAGES-1];
    assign w_uir_synced = r_uir_sync[SYNC_STAGES-1];
    assign w_evt_udr    = w_udr_synced & ~r_udr_prev;
    assign w_evt_uir    = w_uir_synced & ~r_uir_prev;

    assign w_pending    = (r_state == S_PENDING);
    assign w_accept     = w_pending & act_ready;
    // A new capture is allowed when idle, or when the old command retires in the same cycle.
    assign w_capture    = w_evt_udr & (~w_pending | act_ready);
    assign w_drop       = w_evt_udr & w_pending & ~act_ready;
    assign w_cmd_onehot = {{(NCMD-1){1'b0}}, 1'b1} << r_act_cmd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= S_IDLE;
            r_jdo            <= '0;
            r_act_cmd        <= '0;
            r_act_take       <= 1'b0;
            r_take_action    <= '0;
            r_take_no_action <= '0;
            r_ir_update      <= 1'b0;
            r_overrun        <= 1'b0;
        end else begin
            r_take_action    <= '0;
            r_take_no_action <= '0;
            r_ir_update      <= w_evt_uir;

            if (w_accept) begin
                if (r_act_take) begin
                    r_take_action <= w_cmd_onehot;
                end else begin
                    r_take_no_action <= w_cmd_onehot;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_jdo      <= sr;
                        r_act_cmd  <= ir_in;
                        r_act_take <= sr[ACT_BIT];
                        r_state    <= S_PENDING;
                    end
                end
                S_PENDING: begin
                    // A capture here keeps the new command pending even if evt_uir coincides.
                    if (w_capture) begin
                        r_jdo      <= sr;
                        r_act_cmd  <= ir_in;
                        r_act_take <= sr[ACT_BIT];
                    end else if (w_evt_uir || act_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign jdo            = r_jdo;
    assign act_valid      = w_pending;
    assign act_cmd        = r_act_cmd;
    assign act_take       = r_act_take;
    assign take_action    = r_take_action;
    assign take_no_action = r_take_no_action;
    assign ir_update      = r_ir_update;
    assign overrun        = r_overrun;

endmodule
